// File: rtl/zoom_pkg.sv
// Shared constants and state encoding for the zoom window generator.
// Coefficient fraction width is fixed at 4 by the downstream bilinear core.
package zoom_pkg;

  localparam int PW           = 5;
  localparam int AW           = 11;
  localparam int FW           = 4;
  localparam int STEP_W       = 8;
  localparam int ACC_W        = AW + FW;
  localparam int FLUSH_CYCLES = 2;
  localparam int FLUSH_CW     = $clog2(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_REQ = 2'd1,
    RUN     = 2'd2,
    FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/zoom_dda.sv
// Fixed-point DDA accumulator: integer/fraction split, with the integer part
// and its right/lower neighbour clamped to the last valid source index.
module zoom_dda
  import zoom_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [STEP_W-1:0] step,
  input  logic [AW-1:0]     limit,
  output logic [AW-1:0]     int_a,
  output logic [AW-1:0]     int_b,
  output logic [FW-1:0]     frac
);

  logic [ACC_W-1:0] acc;
  logic [AW-1:0]    int_raw;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_W'(step);
    end
  end

  assign int_raw = acc[ACC_W-1:FW];
  assign frac    = acc[FW-1:0];

  // An oversized step can push the integer part past the edge; clamp both taps.
  assign int_a = (int_raw > limit)  ? limit : int_raw;
  assign int_b = (int_raw >= limit) ? limit : int_raw + AW'(1);

endmodule

// File: rtl/zoom_window_gen.sv
// Walks the destination raster, requests source row pairs and presents the
// 2x2 neighbourhood plus dx/dy (and dx*dy one cycle later) to the interpolator.
module zoom_window_gen
  import zoom_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     src_w,
  input  logic [AW-1:0]     src_h,
  input  logic [AW-1:0]     dst_w,
  input  logic [AW-1:0]     dst_h,
  input  logic [STEP_W-1:0] step_x,
  input  logic [STEP_W-1:0] step_y,
  output logic              row_req,
  output logic [AW-1:0]     src_row_top,
  output logic [AW-1:0]     src_row_bot,
  input  logic              row_ack,
  output logic [AW-1:0]     rd_addr_a,
  output logic [AW-1:0]     rd_addr_b,
  input  logic [PW-1:0]     rd_top_a,
  input  logic [PW-1:0]     rd_top_b,
  input  logic [PW-1:0]     rd_bot_a,
  input  logic [PW-1:0]     rd_bot_b,
  output logic              out_valid,
  output logic              out_eol,
  output logic [PW-1:0]     pixel_1,
  output logic [PW-1:0]     pixel_2,
  output logic [PW-1:0]     pixel_3,
  output logic [PW-1:0]     pixel_4,
  output logic [FW-1:0]     dx_out,
  output logic [FW-1:0]     dy_out,
  output logic [2*FW-1:0]   dx_dy,
  output logic              busy,
  output logic              frame_done
);

  state_t state, state_nxt;

  logic [AW-1:0]       x_lim, y_lim, dst_w_l, dst_h_l;
  logic [STEP_W-1:0]   step_x_l, step_y_l;
  logic [AW-1:0]       col_cnt, line_cnt;
  logic [FLUSH_CW-1:0] flush_cnt;

  logic          start_go, zero_size, last_col, last_line, last_flush;
  logic          x_clear, run_issue, y_adv, frame_end;
  logic [FW-1:0] x_frac, y_frac;

  logic          s1_valid, s1_eol;
  logic [FW-1:0] s1_dx, s1_dy;

  assign start_go   = (state == IDLE) && start;
  assign zero_size  = (dst_w == '0) || (dst_h == '0);
  assign last_col   = (col_cnt == dst_w_l - AW'(1));
  assign last_line  = (line_cnt == dst_h_l - AW'(1));
  assign last_flush = (flush_cnt == FLUSH_CW'(FLUSH_CYCLES - 1));
  assign run_issue  = (state == RUN);
  assign x_clear    = (state == ROW_REQ) && row_ack;
  assign y_adv      = (state == FLUSH) && last_flush && !last_line;
  assign frame_end  = (state == FLUSH) && last_flush && last_line;

  assign row_req = (state == ROW_REQ);
  assign busy    = (state != IDLE);

  zoom_dda u_dda_x (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (x_clear),
    .enable (run_issue),
    .step   (step_x_l),
    .limit  (x_lim),
    .int_a  (rd_addr_a),
    .int_b  (rd_addr_b),
    .frac   (x_frac)
  );

  zoom_dda u_dda_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_go),
    .enable (y_adv),
    .step   (step_y_l),
    .limit  (y_lim),
    .int_a  (src_row_top),
    .int_b  (src_row_bot),
    .frac   (y_frac)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the default assignment up front keeps this block purely
  // combinational; a path that left state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !zero_size) state_nxt = ROW_REQ;
      ROW_REQ: if (row_ack)             state_nxt = RUN;
      RUN:     if (last_col)            state_nxt = FLUSH;
      FLUSH:   if (last_flush)          state_nxt = last_line ? IDLE : ROW_REQ;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Frame geometry is frozen at start; limits are stored as last valid index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lim    <= '0;
      y_lim    <= '0;
      dst_w_l  <= '0;
      dst_h_l  <= '0;
      step_x_l <= '0;
      step_y_l <= '0;
    end else if (start_go) begin
      x_lim    <= src_w - AW'(1);
      y_lim    <= src_h - AW'(1);
      dst_w_l  <= dst_w;
      dst_h_l  <= dst_h;
      step_x_l <= step_x;
      step_y_l <= step_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt    <= '0;
      line_cnt   <= '0;
      flush_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      if (x_clear) begin
        col_cnt <= '0;
      end else if (run_issue) begin
        col_cnt <= col_cnt + AW'(1);
      end
      if (start_go) begin
        line_cnt <= '0;
      end else if (y_adv) begin
        line_cnt <= line_cnt + AW'(1);
      end
      if (run_issue) begin
        flush_cnt <= '0;
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt + FLUSH_CW'(1);
      end
      frame_done <= (start_go && zero_size) || frame_end;
    end
  end

  // Stage 1 waits out the RAM latency; stage 2 meets the returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_eol    <= 1'b0;
      s1_dx     <= '0;
      s1_dy     <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      pixel_1   <= '0;
      pixel_2   <= '0;
      pixel_3   <= '0;
      pixel_4   <= '0;
      dx_out    <= '0;
      dy_out    <= '0;
      dx_dy     <= '0;
    end else begin
      s1_valid  <= run_issue;
      s1_eol    <= run_issue && last_col;
      if (run_issue) begin
        s1_dx <= x_frac;
        s1_dy <= y_frac;
      end
      out_valid <= s1_valid;
      out_eol   <= s1_eol;
      if (s1_valid) begin
        pixel_1 <= rd_top_a;
        pixel_2 <= rd_top_b;
        pixel_3 <= rd_bot_a;
        pixel_4 <= rd_bot_b;
        dx_out  <= s1_dx;
        dy_out  <= s1_dy;
      end
      dx_dy <= (2*FW)'(dx_out) * (2*FW)'(dy_out);
    end
  end

endmodule

// File: doc/zoom_window_gen.md
Name: zoom_window_gen

Overview:
- Upstream feeder for the 2x2 bilinear interpolator core.
- Walks the destination raster using 11.4 fixed-point DDA accumulators.
- Requests source row pairs from the line-buffer controller, reads the 2x2 source neighbourhood, and presents pixel_1..4, dx, dy and dx*dy.
- Output timing is aligned to the interpolator's input contract: dx_dy arrives one cycle after dx/dy.

Parameters:
- PW, 5, pixel width.
- AW, 11, source/destination coordinate width.
- FW, 4, fractional bits of coefficients. Fixed at 4 by the downstream core; other values are unsupported.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame. Ignored unless the block is in IDLE.
- src_w  in  AW  source width in pixels (≥1).
- src_h  in  AW  source height in pixels (≥1).
- dst_w  in  AW  destination width.
- dst_h  in  AW  destination height.
- step_x  in  8  horizontal step in 4.4 format (src/dst ratio).
- step_y  in  8  vertical step in 4.4 format.
- row_req  out  1  request line buffer to present rows src_row_top and src_row_bot.
- src_row_top  out  AW  integer y.
- src_row_bot  out  AW  min(y+1, src_h-1).
- row_ack  in  1  line buffer holds the requested rows. Handshake completes when row_req && row_ack.
- rd_addr_a  out  AW  column x.
- rd_addr_b  out  AW  min(x+1, src_w-1).
- rd_top_a  in  PW  top row at rd_addr_a. Synchronous RAM, 1-cycle latency.
- rd_top_b  in  PW  top row at rd_addr_b.
- rd_bot_a  in  PW  bottom row at rd_addr_a.
- rd_bot_b  in  PW  bottom row at rd_addr_b.
- out_valid  out  1  pixel_1..4, dx_out and dy_out are valid this cycle.
- out_eol  out  1  last pixel of the destination line. Qualified by out_valid.
- pixel_1  out  PW  (1,1) = top_a.
- pixel_2  out  PW  (1,2) = top_b.
- pixel_3  out  PW  (2,1) = bot_a.
- pixel_4  out  PW  (2,2) = bot_b.
- dx_out  out  FW  x fractional part.
- dy_out  out  FW  y fractional part.
- dx_dy  out  2*FW  registered dx_out*dy_out, valid one cycle after the matching dx_out/dy_out.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs and internal registers are 0; state is IDLE. Reset is asynchronous, so asserting it mid-frame aborts immediately. No frame_done is produced for the aborted frame.
- On start in IDLE:
  - Latch src_w, src_h, dst_w, dst_h, step_x, step_y; later changes to these inputs are ignored until IDLE.
  - Clear y_acc and the line counter.
  - If dst_w==0 or dst_h==0: pulse frame_done on the next cycle and stay in IDLE.
  - Otherwise go to ROW_REQ.
- ROW_REQ:
  - row_req=1, with src_row_top = y_acc[14:4] and src_row_bot = clamped value.
  - On row_ack: clear x_acc and the column counter, go to RUN.
  - row_req stays high until acknowledged. An ack in the same cycle as the request is legal.
- RUN: one destination pixel per cycle, for dst_w cycles.
  - rd_addr_a = x_acc[14:4]; rd_addr_b = clamped value.
  - Pipeline stage 1 captures x_acc[3:0] and y_acc[3:0].
  - x_acc += step_x each cycle.
  - After dst_w issues, go to FLUSH.
- Timing: addresses are registered at edge t and RAM data is valid after edge t+1. Output registers load at edge t+2, so out_valid rises 2 cycles after the first RUN cycle. dx_dy follows one cycle later.
- FLUSH: 2 cycles, draining the pipeline. Then:
  - Last line: pulse frame_done, go to IDLE.
  - Otherwise: y_acc += step_y, increment the line counter, go to ROW_REQ.
- Clamping:
  - x_int ≥ src_w-1 gives rd_addr_b = src_w-1; y_int ≥ src_h-1 gives src_row_bot = src_h-1.
  - The fraction passes unchanged; p2==p1 (or p3==p1) makes it harmless.
  - x_int or y_int beyond src-1 (bad step setting) clamps rd_addr_a and src_row_top as well.
- Accumulator widths: AW+FW bits, wrapping modulo 2^15. The wrap is unreachable with legal steps.
- out_eol is asserted together with the out_valid of column dst_w-1.
- out_valid is never asserted during ROW_REQ, apart from pixels still draining.
- No backpressure: the downstream core consumes one pixel per cycle unconditionally.

Decomposition:
- Shared package zoom_pkg holds:
  - PW, AW, FW.
  - The state encoding (IDLE, ROW_REQ, RUN, FLUSH).
  - FLUSH_CYCLES=2.
- One sub-module, zoom_dda: an accumulator with step input, clear, enable, integer/fraction split and clamp against a limit.
  - Instantiated twice, once for x and once for y.

Test Plan:
- Identity scale: src 4x2, dst 4x2, step 0x10, ramp source. Expect dx_out=dy_out=0 every pixel, pixel_1 equals the source pixel, 8 out_valid, out_eol on columns 3, frame_done once.
- 2x upscale: src_w=4, dst_w=8, step_x=0x08. Expect dx_out sequence 0,8,0,8,…; rd_addr_a 0,0,1,1,2,2,3,3; rd_addr_b clamped to 3 on the last two; dx_dy = dx*dy one cycle later.
- Vertical walk: src_h=3, dst_h=5, step_y=0x09. Expect row requests (top,bot) = (0,1),(0,1),(1,2),(1,2),(2,2), with dy_out 0,9,2,11,4.
- Row handshake: hold row_ack low for 5 cycles. Expect row_req to stay high, no out_valid, and RUN to start the cycle after the ack.
- Start while busy, plus zero size: start pulses during RUN are ignored (frame content unchanged); dst_w=0 gives frame_done 1 cycle after start and no row_req.
- Reset mid-line: drop rst_n during RUN. Expect outputs cleared immediately, IDLE, no frame_done; a new start runs a clean frame.
